// File: rtl/regfile_fwd.sv
// regfile_fwd: 32 x 32-bit register file for the ID stage. It has combinational
// reads, a write-through bypass from WB, an optional EX/MEM forwarding network,
// a load-use stall request and a counter of committed writes.
//
// Configuration macro:
//   RF_FWD_EN  defined   -> the EX/MEM/WB forwarding network is included.
//                           stallreq is raised only for a load-use hazard.
//              undefined -> only the WB bypass and the array feed the read
//                           ports. stallreq is raised for any EX or MEM hit.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wb_to_rf_bus[37:0]       {we, waddr[4:0], wdata[31:0]} from writeback
//   ex_we/ex_waddr/ex_wdata  EX-stage result
//   ex_is_load               the EX-stage instruction is a load
//   mem_we/mem_waddr/mem_wdata  MEM-stage result
//   raddr1, raddr2           ID-stage read addresses
//   rdata1, rdata2           resolved operands
//   stallreq                 stall request to the stall controller
//   wr_cnt[CNT_W-1:0]        count of committed writes (wraps)
module regfile_fwd #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [37:0]      wb_to_rf_bus,
  input  logic             ex_we,
  input  logic [4:0]       ex_waddr,
  input  logic [31:0]      ex_wdata,
  input  logic             ex_is_load,
  input  logic             mem_we,
  input  logic [4:0]       mem_waddr,
  input  logic [31:0]      mem_wdata,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  output logic [31:0]      rdata1,
  output logic [31:0]      rdata2,
  output logic             stallreq,
  output logic [CNT_W-1:0] wr_cnt
);

  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_commit;
  logic [31:0] regs [32];

  assign wb_we     = wb_to_rf_bus[37];
  assign wb_waddr  = wb_to_rf_bus[36:32];
  assign wb_wdata  = wb_to_rf_bus[31:0];
  assign wb_commit = wb_we && (wb_waddr != 5'd0);

  // A stage hits a read port only when it writes a nonzero matching address.
  function automatic logic hit(input logic we, input logic [4:0] waddr,
                               input logic [4:0] raddr);
    return we && (waddr == raddr) && (raddr != 5'd0);
  endfunction

  // Operand resolution. The youngest producer wins, then the array.
  function automatic logic [31:0] resolve(input logic [4:0] raddr);
    logic [31:0] val;
    if (raddr == 5'd0)                    val = 32'd0;
`ifdef RF_FWD_EN
    else if (hit(ex_we, ex_waddr, raddr))   val = ex_wdata;
    else if (hit(mem_we, mem_waddr, raddr)) val = mem_wdata;
`endif
    else if (hit(wb_we, wb_waddr, raddr))   val = wb_wdata;
    else                                  val = regs[raddr];
    return val;
  endfunction

  always_comb begin
    rdata1 = resolve(raddr1);
    rdata2 = resolve(raddr2);
  end

`ifdef RF_FWD_EN
  // Only a load in EX has no value yet. It is forwarded from MEM next cycle.
  always_comb begin
    stallreq = ex_is_load &&
               (hit(ex_we, ex_waddr, raddr1) || hit(ex_we, ex_waddr, raddr2));
  end
`else
  // Without forwarding, any in-flight producer of an operand must drain to WB.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_wdata, mem_wdata, ex_is_load};

  always_comb begin
    stallreq = hit(ex_we, ex_waddr, raddr1)   || hit(ex_we, ex_waddr, raddr2) ||
               hit(mem_we, mem_waddr, raddr1) || hit(mem_we, mem_waddr, raddr2);
  end
`endif

  // Register array and write counter. A WB write is dropped during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      wr_cnt <= '0;
    end else if (wb_commit) begin
      regs[wb_waddr] <= wb_wdata;
      wr_cnt         <= wr_cnt + 1'b1;
    end
  end

endmodule
